crc4_frame_tx: RTL

CRC4_FRAME_TX -- requirements
Module: crc4_frame_tx

---
 rtl/crc_tx_pkg.sv | 23 ++
 rtl/crc4_nibble.sv | 30 +++
 rtl/crc4_frame_tx.sv | 103 ++++++++++
 3 files changed

// File: rtl/crc_tx_pkg.sv
// Shared definitions for the CRC-4 frame transmitter slice.
//   state_t      : FSM states (IDLE / CALC / SEND)
//   DATA_W, CRC_W, CHAN_W, CNT_W, NIB_W : datapath widths
//   POLY_DEFAULT : generator low terms for x^4+x+1
//   INIT_DEFAULT : CRC register preset at the start of each word
package crc_tx_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CRC_W  = 4;
  localparam int unsigned CHAN_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NIB_W  = 4;

  localparam logic [CRC_W-1:0] POLY_DEFAULT = 4'h3;
  localparam logic [CRC_W-1:0] INIT_DEFAULT = 4'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/crc4_nibble.sv
// Combinational CRC-4 step over one nibble, bits taken MSB first,
// non-reflected.
//   crc     : current CRC register
//   nib     : nibble to fold in (bit 3 enters first)
//   crc_nxt : CRC register after the four bit steps
module crc4_nibble
  import crc_tx_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = POLY_DEFAULT
) (
  input  logic [CRC_W-1:0] crc,
  input  logic [NIB_W-1:0] nib,
  output logic [CRC_W-1:0] crc_nxt
);

  logic [CRC_W-1:0] c;

  always_comb begin
    c = crc;
    for (int unsigned i = 0; i < NIB_W; i++) begin
      if (c[CRC_W-1] ^ nib[NIB_W-1-i]) begin
        c = {c[CRC_W-2:0], 1'b0} ^ POLY;
      end else begin
        c = {c[CRC_W-2:0], 1'b0};
      end
    end
    crc_nxt = c;
  end

endmodule

// File: rtl/crc4_frame_tx.sv
// CRC-4 frame transmitter. Accepts a 64-bit word with a channel tag,
// spends 16 cycles folding it into a CRC-4 one nibble per cycle, then
// presents word, CRC and channel until the downstream handshake.
//   clock, reset        : rising-edge clock, async active-high reset
//   in_valid / in_ready : input handshake (ready only in IDLE)
//   in_chan, in_data    : channel tag and payload captured on accept
//   Data, CRC, out_chan : held output word, its CRC-4 and channel
//   out_valid/out_ready : output handshake (valid only in SEND)
//   frame_cnt           : completed output handshakes, wraps silently
module crc4_frame_tx
  import crc_tx_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = POLY_DEFAULT,
  parameter logic [CRC_W-1:0] INIT = INIT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] Data,
  output logic [CRC_W-1:0]  CRC,
  output logic [CHAN_W-1:0] out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_t            state_q;
  logic [DATA_W-1:0] data_q;
  logic [CRC_W-1:0]  crc_q;
  logic [CHAN_W-1:0] chan_q;
  logic [NIB_W-1:0]  nib_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NIB_W-1:0]  cur_nib;
  logic [CRC_W-1:0]  crc_nxt;
  logic [5:0]        nib_lsb;

  // Nibble index 0 maps to bits [63:60]: bit offset is (15 - idx) * 4,
  // i.e. the inverted index with two zero LSBs.
  always_comb begin
    nib_lsb = {~nib_q, 2'b00};
    cur_nib = data_q[nib_lsb +: NIB_W];
  end

  crc4_nibble #(
    .POLY(POLY)
  ) u_step (
    .crc    (crc_q),
    .nib    (cur_nib),
    .crc_nxt(crc_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      crc_q   <= '0;
      chan_q  <= '0;
      nib_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            chan_q  <= in_chan;
            crc_q   <= INIT;
            nib_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          crc_q <= crc_nxt;
          nib_q <= nib_q + 1'b1;
          // Wrap of the 4-bit counter from 15 ends the word: exactly 16 steps.
          if (nib_q == '1) begin
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SEND);
    Data      = data_q;
    CRC       = crc_q;
    out_chan  = chan_q;
    frame_cnt = cnt_q;
  end

endmodule
